// File: rtl/mpu_add_sequencer.sv
// rtl/mpu_add_sequencer.sv - row-by-row C = A + B sequencer driving the shared SIMD adder
module mpu_add_sequencer #(
    parameter int NUM_BITS = 512,
    parameter int ADDR_W   = 8,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_a_base,
    input  logic [ADDR_W-1:0]   src_b_base,
    input  logic [ADDR_W-1:0]   dst_base,
    input  logic [CNT_W-1:0]    num_rows,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr_a,
    output logic [ADDR_W-1:0]   rd_addr_b,
    input  logic [NUM_BITS-1:0] rd_data_a,
    input  logic [NUM_BITS-1:0] rd_data_b,
    output logic [NUM_BITS-1:0] add_dd,
    output logic [NUM_BITS-1:0] add_aa,
    input  logic [NUM_BITS-1:0] add_sum,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [NUM_BITS-1:0] wr_data,
    input  logic                wr_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_WRITE,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    row_q, row_d;
    logic [CNT_W-1:0]    nrows_q, nrows_d;
    logic [ADDR_W-1:0]   a_base_q, a_base_d;
    logic [ADDR_W-1:0]   b_base_q, b_base_d;
    logic [ADDR_W-1:0]   d_base_q, d_base_d;
    logic [NUM_BITS-1:0] add_dd_q, add_aa_q;
    logic [ADDR_W-1:0]   row_off;

    // Row index is zero-extended or truncated to address width; sums wrap modulo 2^ADDR_W.
    assign row_off = ADDR_W'(row_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            nrows_q  <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            d_base_q <= '0;
            add_dd_q <= '0;
            add_aa_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            nrows_q  <= nrows_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            d_base_q <= d_base_d;
            if (state_q == S_LATCH) begin
                add_dd_q <= rd_data_a;
                add_aa_q <= rd_data_b;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        nrows_d  = nrows_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        d_base_d = d_base_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_base_d = src_a_base;
                    b_base_d = src_b_base;
                    d_base_d = dst_base;
                    nrows_d  = num_rows;
                    row_d    = '0;
                    state_d  = (num_rows == '0) ? S_FIN : S_READ;
                end
            end
            S_READ:  state_d = S_LATCH;
            S_LATCH: state_d = S_WRITE;
            S_WRITE: begin
                if (wr_ready) begin
                    if (row_q == nrows_q - CNT_W'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        row_d   = row_q + CNT_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN);
        rd_en     = (state_q == S_READ);
        wr_en     = (state_q == S_WRITE);
        rd_addr_a = '0;
        rd_addr_b = '0;
        wr_addr   = '0;
        if (state_q == S_READ) begin
            rd_addr_a = a_base_q + row_off;
            rd_addr_b = b_base_q + row_off;
        end
        if (state_q == S_WRITE) begin
            wr_addr = d_base_q + row_off;
        end
    end

    assign add_dd  = add_dd_q;
    assign add_aa  = add_aa_q;
    assign wr_data = add_sum;

endmodule

// File: tb/tb_mpu_add_sequencer.sv
// tb/tb_mpu_add_sequencer.sv - self-checking bench for mpu_add_sequencer
module tb_mpu_add_sequencer;

    localparam int NB = 512;
    localparam int AW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_a_base = '0, src_b_base = '0, dst_base = '0;
    logic [CW-1:0] num_rows = '0;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
    logic [NB-1:0] rd_data_a = '0, rd_data_b = '0;
    logic [NB-1:0] add_dd, add_aa, add_sum, wr_data;
    logic          wr_ready = 1'b1;

    always #5 clk = ~clk;

    mpu_add_sequencer #(.NUM_BITS(NB), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_a_base(src_a_base), .src_b_base(src_b_base), .dst_base(dst_base),
        .num_rows(num_rows), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .add_dd(add_dd), .add_aa(add_aa), .add_sum(add_sum),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
    );

    // External SIMD adder: 64 independent 8-bit lanes, carries dropped per lane.
    function automatic logic [NB-1:0] lane_add(input logic [NB-1:0] x, input logic [NB-1:0] y);
        logic [NB-1:0] s;
        for (int i = 0; i < NB / 8; i++) s[i*8 +: 8] = x[i*8 +: 8] + y[i*8 +: 8];
        return s;
    endfunction

    always_comb add_sum = lane_add(add_dd, add_aa);

    function automatic logic [NB-1:0] rand_row();
        logic [NB-1:0] v;
        for (int i = 0; i < NB / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    logic [NB-1:0] mem_a [256];
    logic [NB-1:0] mem_b [256];

    int compared = 0, mismatched = 0;

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: expected transactions of the command in flight.
    logic [AW-1:0] exp_ra[$], exp_rb[$], exp_wa[$];
    logic [NB-1:0] exp_wd[$];
    int            cyc = 0, base_cyc = 0, idx = 0;
    bit            running = 0;
    int            exp_done_idx = 0, done_idx = -1, done_cnt = 0, wr_count = 0, stall_budget = 0;
    bit            stalled_prev = 0, rd_pend = 0;
    logic [AW-1:0] pend_a, pend_b, st_addr;
    logic [NB-1:0] st_data, last_wr_data;

    // Compare process plus operand-buffer and destination responders, all off the falling edge.
    always @(negedge clk) begin
        cyc++;
        idx = cyc - base_cyc;
        if (rd_pend) begin
            rd_data_a = mem_a[pend_a];
            rd_data_b = mem_b[pend_b];
        end else begin
            rd_data_a = rand_row();
            rd_data_b = rand_row();
        end
        rd_pend = rd_en;
        pend_a  = rd_addr_a;
        pend_b  = rd_addr_b;
        if (rst_n) begin
            chk("busy", busy, running && idx >= 1 && idx <= exp_done_idx);
            if (rd_en) begin
                if (exp_ra.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    chk("rd_addr_a", rd_addr_a, exp_ra.pop_front());
                    chk("rd_addr_b", rd_addr_b, exp_rb.pop_front());
                end
            end
            if (wr_en) begin
                if (stalled_prev) begin
                    chk("stall_addr", wr_addr, st_addr);
                    chk("stall_data", wr_data, st_data);
                end
                if (stall_budget > 0) begin
                    stall_budget--;
                    wr_ready     = 1'b0;
                    stalled_prev = 1'b1;
                    st_addr      = wr_addr;
                    st_data      = wr_data;
                end else begin
                    wr_ready     = 1'b1;
                    stalled_prev = 1'b0;
                    wr_count++;
                    last_wr_data = wr_data;
                    if (exp_wa.size() == 0) chk("wr_unexpected", 1, 0);
                    else begin
                        chk("wr_addr", wr_addr, exp_wa.pop_front());
                        chk("wr_data", wr_data, exp_wd.pop_front());
                    end
                end
            end else begin
                wr_ready     = 1'b1;
                stalled_prev = 1'b0;
            end
            if (done) begin
                done_idx = idx;
                done_cnt++;
                if (!running) chk("done_unexpected", 1, 0);
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic run_cmd(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d,
                           input int n, input int stalls, input bit dup, input int done_lit);
        logic [AW-1:0] off;
        for (int r = 0; r < n; r++) begin
            off = AW'(r);
            exp_ra.push_back(a + off);
            exp_rb.push_back(b + off);
            exp_wa.push_back(d + off);
            exp_wd.push_back(lane_add(mem_a[a + off], mem_b[b + off]));
        end
        exp_done_idx = 3 * n + 1 + stalls;
        stall_budget = stalls;
        wr_count = 0;
        done_idx = -1;
        done_cnt = 0;
        @(posedge clk); #2;
        src_a_base = a; src_b_base = b; dst_base = d; num_rows = CW'(n); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        base_cyc = cyc;
        running = 1'b1;
        if (dup) begin
            @(posedge clk); #2;
            src_a_base = 8'h77; src_b_base = 8'h78; dst_base = 8'h79; num_rows = 8'd5; start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
        end
        for (int k = 0; k < 200 && done_idx < 0; k++) @(posedge clk);
        if (done_idx < 0) chk("done_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #2;
        chk("done_cycle", done_idx, done_lit);
        chk("done_count", done_cnt, 1);
        chk("wr_count", wr_count, n);
        chk("rd_left", exp_ra.size(), 0);
        chk("wr_left", exp_wa.size(), 0);
        running = 1'b0;
        exp_ra.delete(); exp_rb.delete(); exp_wa.delete(); exp_wd.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_addr_a", rd_addr_a, 0);
        chk("rst_rd_addr_b", rd_addr_b, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_add_dd", add_dd, 0);
        chk("rst_add_aa", add_aa, 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Single row, lane0 1 + 2.
        mem_a[8'h05] = 512'h1;
        mem_b[8'h40] = 512'h2;
        run_cmd(8'h05, 8'h40, 8'h80, 1, 0, 0, 4);
        chk("t1_sum", last_wr_data, 512'h3);

        // Carry isolation: 0xFF + 0x01 in every lane gives 0x00 everywhere.
        mem_a[8'h06] = {64{8'hFF}};
        mem_b[8'h41] = {64{8'h01}};
        run_cmd(8'h06, 8'h41, 8'h81, 1, 0, 0, 4);
        chk("t2_sum", last_wr_data, 512'h0);

        // Four rows with A address wrap, plus an ignored start while busy.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) begin
                mem_a[8'hFE + 8'(r)][i*8 +: 8] = 8'(r * 16 + i);
                mem_b[8'h10 + 8'(r)][i*8 +: 8] = 8'(255 - i * 3 + r);
            end
        end
        mem_a[8'h01] = {64{8'h90}};
        mem_b[8'h13] = {64{8'h85}};
        run_cmd(8'hFE, 8'h10, 8'h20, 4, 0, 1, 13);
        chk("t3_last_sum", last_wr_data, {64{8'h15}});

        // Backpressure: three stalled cycles on the first write.
        mem_a[8'h30] = rand_row(); mem_a[8'h31] = rand_row();
        mem_b[8'h50] = rand_row(); mem_b[8'h51] = rand_row();
        run_cmd(8'h30, 8'h50, 8'h60, 2, 3, 0, 10);

        // Zero rows.
        run_cmd(8'h00, 8'h00, 8'h00, 0, 0, 0, 1);

        // Reset asserted while a write is stalled.
        exp_ra.push_back(8'h30); exp_rb.push_back(8'h50);
        exp_done_idx = 1000;
        stall_budget = 100;
        done_cnt = 0;
        @(posedge clk); #2;
        src_a_base = 8'h30; src_b_base = 8'h50; dst_base = 8'h70; num_rows = 8'd2; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; base_cyc = cyc; running = 1'b1;
        for (int k = 0; k < 20 && !wr_en; k++) begin
            @(posedge clk); #2;
        end
        chk("t5_in_write", wr_en, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        running = 1'b0;
        stall_budget = 0;
        exp_ra.delete(); exp_rb.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        chk("t5_wr_en", wr_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_add_dd", add_dd, 0);
        repeat (8) @(posedge clk);
        #2;
        chk("t5_no_done", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mpu_add_sequencer.md
Name: mpu_add_sequencer

Overview:
- Sequences element-wise matrix addition, C = A + B, through the shared 512-bit SIMD Adder. The Adder is combinational and split into 64 independent 8-bit lanes.
- Fetches one row of A and one row of B per step from the operand buffers, presents them to the Adder, and writes the sum row to the destination buffer.
- Sits between the MPU command decoder and the operand/result buffers. The Adder is instantiated outside this block; this block drives its inputs and reads its output.

Parameters:
- NUM_BITS, 512, row width in bits; the Adder width.
- ADDR_W, 8, buffer address width in bits (row granularity).
- CNT_W, 8, width of the row-count field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- src_a_base  in  ADDR_W  first row address of A.
- src_b_base  in  ADDR_W  first row address of B.
- dst_base  in  ADDR_W  first row address of C.
- num_rows  in  CNT_W  number of rows to add; 0 is legal.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- rd_en  out  1  read strobe to both operand buffers.
- rd_addr_a  out  ADDR_W  A buffer read address.
- rd_addr_b  out  ADDR_W  B buffer read address.
- rd_data_a  in  NUM_BITS  A row; valid exactly 1 cycle after rd_en.
- rd_data_b  in  NUM_BITS  B row; valid exactly 1 cycle after rd_en.
- add_dd  out  NUM_BITS  registered operand to Adder dd (A row).
- add_aa  out  NUM_BITS  registered operand to Adder aa (B row).
- add_sum  in  NUM_BITS  Adder sum output.
- wr_en  out  1  destination write request.
- wr_addr  out  ADDR_W  destination row address.
- wr_data  out  NUM_BITS  equals add_sum (combinational passthrough); meaningful only when wr_en=1.
- wr_ready  in  1  destination accepts the write on a clock edge where wr_en=1 and wr_ready=1.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE; the row index, latched command and add_dd/add_aa are cleared to 0.
  - busy, done, rd_en and wr_en are 0; all addresses are 0.
  - Reset mid-operation aborts immediately. No further reads or writes are issued and no done pulse follows.
- State machine: IDLE, READ, LATCH, WRITE, FIN.
  - IDLE: if start=1, latch the bases and num_rows and clear row index r. If num_rows=0, go to FIN; otherwise go to READ.
  - READ: rd_en=1, rd_addr_a=src_a_base+r, rd_addr_b=src_b_base+r. Go to LATCH.
  - LATCH: register rd_data_a into add_dd and rd_data_b into add_aa. Go to WRITE.
  - WRITE: wr_en=1, wr_addr=dst_base+r, wr_data=add_sum.
    - Hold WRITE, with address and data stable, while wr_ready=0.
    - On acceptance: if r=num_rows-1, go to FIN; otherwise increment r and go to READ.
  - FIN: done=1 for exactly one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W, so a base plus r wraps silently.
- Lane semantics are the Adder's: 8-bit lanes, no carry between lanes, overflow discarded per lane. This block does not modify data.
- start while busy=1 is ignored, with no queuing. Command inputs are ignored outside IDLE.
- Timing, with wr_ready held at 1 and start sampled at edge E0:
  - 3 cycles per row.
  - done is high during cycle 3N+1 after E0; for N=0, during cycle 1.
  - busy deasserts in the cycle after done.
- Each wr_ready=0 cycle in WRITE adds exactly one cycle of latency.
- add_dd/add_aa hold their last values in IDLE.

Test Plan:
- Reset, then idle: all outputs 0, busy=0; start=0 for 10 cycles -> no rd_en or wr_en.
- num_rows=1, A row has lane0=0x01, B row has lane0=0x02, all other lanes 0, wr_ready=1 -> one write of lane0=0x03 at dst_base; done pulses in cycle 4 after start.
- Per-lane carry isolation: every A lane 0xFF, every B lane 0x01 -> written row is all 0x00, with no lane reading 0x01.
- num_rows=4, src_a_base=0xFE, src_b_base=0x10, dst_base=0x20, with a distinct lane pattern per row -> read addresses 0xFE,0xFF,0x00,0x01 (A) and 0x10..0x13 (B); writes at 0x20..0x23 with correct sums; done in cycle 13; second start during busy ignored.
- Backpressure: num_rows=2, wr_ready=0 for 3 cycles on the first write -> wr_addr/wr_data stable throughout; done delayed to cycle 10; exactly 2 writes.
- num_rows=0 -> done in cycle 1, no rd_en/wr_en. Reset asserted mid-WRITE -> next cycle IDLE, wr_en=0, no done pulse.
